// File: rtl/fetch_controller.sv
// fetch_controller: sequences the SLC-3 instruction fetch.
// Steps MAR<-PC / PC<-PC+1, holds a multi-cycle memory read into MDR,
// loads IR from MDR, then pauses with IR on the LEDs until Continue is
// pressed and released.
//
// state  | meaning
// -------+------------------------------------------------------------
// HALTED | idle after reset; waits for Run
// S18    | MAR<-PC, PC<-PC+1 (GatePC, LD_MAR, LD_PC)
// S33    | memory read held for MEM_WAIT cycles; LD_MDR in the last one
// S35    | IR<-MDR (GateMDR, LD_IR); fetch_count bumps at the closing edge
// PAUSE1 | IR shown on the LEDs; waits for Continue to rise
// PAUSE2 | waits for Continue to fall, so one press gives one fetch
//
// All outputs are registered.  They are decoded from the next state, so
// each output flop holds the Moore decode of the state flop beside it.
// Reset clears state and outputs together, so no partial load pulse
// can survive an asynchronous reset.
module fetch_controller #(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        MIO_EN,
  output logic        Mem_OE_N,
  output logic        Mem_WE_N,
  output logic [15:0] fetch_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    S18    = 3'd1,
    S33    = 3'd2,
    S35    = 3'd3,
    PAUSE1 = 3'd4,
    PAUSE2 = 3'd5
  } state_t;

  // The read ends when the counter reaches MEM_WAIT-1 (MEM_WAIT is 1..15).
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic ld_mar_q, ld_mar_d;
  logic ld_mdr_q, ld_mdr_d;
  logic ld_ir_q, ld_ir_d;
  logic ld_pc_q, ld_pc_d;
  logic ld_led_q, ld_led_d;
  logic gate_pc_q, gate_pc_d;
  logic gate_mdr_q, gate_mdr_d;
  logic mio_en_q, mio_en_d;
  logic mem_oe_n_q, mem_oe_n_d;
  logic busy_q, busy_d;

  // Next-state, wait counter and fetch counter.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      HALTED: begin
        if (Run) state_d = S18;
      end
      S18: begin
        state_d = S33;
        wait_d  = 4'd0;
      end
      S33: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S35;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S35: begin
        fetch_count_d = fetch_count_q + 16'd1;
        state_d       = PAUSE1;
      end
      PAUSE1: begin
        if (Continue) state_d = PAUSE2;
      end
      PAUSE2: begin
        if (!Continue) state_d = S18;
      end
      default: begin
        state_d = HALTED;
        wait_d  = 4'd0;
      end
    endcase
  end

  // Output decode for the state being entered, so the flops line up with it.
  always_comb begin
    ld_mar_d   = 1'b0;
    ld_mdr_d   = 1'b0;
    ld_ir_d    = 1'b0;
    ld_pc_d    = 1'b0;
    ld_led_d   = 1'b0;
    gate_pc_d  = 1'b0;
    gate_mdr_d = 1'b0;
    mio_en_d   = 1'b0;
    mem_oe_n_d = 1'b1;
    busy_d     = (state_d != HALTED);
    case (state_d)
      S18: begin
        gate_pc_d = 1'b1;
        ld_mar_d  = 1'b1;
        ld_pc_d   = 1'b1;
      end
      S33: begin
        mem_oe_n_d = 1'b0;
        mio_en_d   = 1'b1;
        ld_mdr_d   = (wait_d == WAIT_LAST);
      end
      S35: begin
        gate_mdr_d = 1'b1;
        ld_ir_d    = 1'b1;
      end
      PAUSE1: begin
        ld_led_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= HALTED;
      wait_q        <= 4'd0;
      fetch_count_q <= 16'h0000;
      ld_mar_q      <= 1'b0;
      ld_mdr_q      <= 1'b0;
      ld_ir_q       <= 1'b0;
      ld_pc_q       <= 1'b0;
      ld_led_q      <= 1'b0;
      gate_pc_q     <= 1'b0;
      gate_mdr_q    <= 1'b0;
      mio_en_q      <= 1'b0;
      mem_oe_n_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      fetch_count_q <= fetch_count_d;
      ld_mar_q      <= ld_mar_d;
      ld_mdr_q      <= ld_mdr_d;
      ld_ir_q       <= ld_ir_d;
      ld_pc_q       <= ld_pc_d;
      ld_led_q      <= ld_led_d;
      gate_pc_q     <= gate_pc_d;
      gate_mdr_q    <= gate_mdr_d;
      mio_en_q      <= mio_en_d;
      mem_oe_n_q    <= mem_oe_n_d;
      busy_q        <= busy_d;
    end
  end

  assign LD_MAR      = ld_mar_q;
  assign LD_MDR      = ld_mdr_q;
  assign LD_IR       = ld_ir_q;
  assign LD_PC       = ld_pc_q;
  assign LD_LED      = ld_led_q;
  assign GatePC      = gate_pc_q;
  assign GateMDR     = gate_mdr_q;
  assign MIO_EN      = mio_en_q;
  assign Mem_OE_N    = mem_oe_n_q;
  assign busy        = busy_q;
  assign fetch_count = fetch_count_q;

  // Execute-phase drivers; never used during fetch.
  assign GateALU    = 1'b0;
  assign GateMARMUX = 1'b0;
  // PC+1 is the only source used by fetch.
  assign PCMUX      = 2'b00;
  // Fetch only reads memory.
  assign Mem_WE_N   = 1'b1;

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: per-cycle expected output vectors are
// queued when stimulus is applied and compared as the DUT produces them.
module tb_fetch_controller;

  logic        Clk, Reset, Run, Continue;
  logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_LED;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX;
  logic        MIO_EN, Mem_OE_N, Mem_WE_N, busy;
  logic [15:0] fetch_count;

  typedef struct packed {
    logic       busy, ld_mar, ld_mdr, ld_ir, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       mio_en, oe_n, we_n;
  } ovec_t;

  localparam int ST_H = 0, ST_S18 = 1, ST_S33 = 2, ST_S35 = 3, ST_P1 = 4, ST_P2 = 5;

  ovec_t obs;
  ovec_t sb_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  assign obs = {busy, LD_MAR, LD_MDR, LD_IR, LD_PC, LD_LED, GatePC, GateMDR,
                GateALU, GateMARMUX, PCMUX, MIO_EN, Mem_OE_N, Mem_WE_N};

  fetch_controller #(.MEM_WAIT(2)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .MIO_EN(MIO_EN), .Mem_OE_N(Mem_OE_N), .Mem_WE_N(Mem_WE_N),
    .fetch_count(fetch_count), .busy(busy)
  );

  // Extra instances for the shortest and longest memory wait.
  localparam int WV [2] = '{1, 15};
  logic        run_x [2];
  logic        oe_x [2], mdr_x [2];
  logic        j_mar [2], j_ir [2], j_pc [2], j_led [2], j_gpc [2], j_gmdr [2];
  logic        j_galu [2], j_gmm [2], j_mio [2], j_we [2], j_busy [2];
  logic [1:0]  j_pcmux [2];
  logic [15:0] j_fc [2];

  for (genvar g = 0; g < 2; g++) begin : g_wait
    fetch_controller #(.MEM_WAIT(WV[g])) u_dut (
      .Clk(Clk), .Reset(Reset), .Run(run_x[g]), .Continue(1'b0),
      .LD_MAR(j_mar[g]), .LD_MDR(mdr_x[g]), .LD_IR(j_ir[g]), .LD_PC(j_pc[g]),
      .LD_LED(j_led[g]), .GatePC(j_gpc[g]), .GateMDR(j_gmdr[g]), .GateALU(j_galu[g]),
      .GateMARMUX(j_gmm[g]), .PCMUX(j_pcmux[g]), .MIO_EN(j_mio[g]), .Mem_OE_N(oe_x[g]),
      .Mem_WE_N(j_we[g]), .fetch_count(j_fc[g]), .busy(j_busy[g])
    );
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic ovec_t ev(input int st, input bit mdr);
    ovec_t v;
    v      = '0;
    v.oe_n = 1'b1;
    v.we_n = 1'b1;
    case (st)
      ST_S18: begin v.busy = 1; v.ld_mar = 1; v.ld_pc = 1; v.gate_pc = 1; end
      ST_S33: begin v.busy = 1; v.ld_mdr = mdr; v.mio_en = 1; v.oe_n = 1'b0; end
      ST_S35: begin v.busy = 1; v.ld_ir = 1; v.gate_mdr = 1; end
      ST_P1:  begin v.busy = 1; v.ld_led = 1; end
      ST_P2:  begin v.busy = 1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push_n(input int st, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(ev(st, 1'b0));
  endtask

  task automatic push_fetch(input int w);
    sb_q.push_back(ev(ST_S18, 1'b0));
    for (int i = 0; i < w; i++) sb_q.push_back(ev(ST_S33, i == w - 1));
    sb_q.push_back(ev(ST_S35, 1'b0));
    sb_q.push_back(ev(ST_P1, 1'b0));
  endtask

  // One compare per falling edge; Run is a single-cycle request.
  task automatic drain(input int n);
    ovec_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Run = 1'b0;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("out_vec", obs, e);
        check("one_gate", 32'($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1), 32'd1);
      end
    end
  endtask

  initial begin
    int oe_cnt [2], mdr_cnt [2], mdr_at [2], mdr_oe [2], runs [2];
    logic prev_oe [2];
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0;
    run_x[0] = 1'b0; run_x[1] = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("rst_vec", obs, ev(ST_H, 1'b0));
    check("rst_count", fetch_count, 16'h0000);
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    push_n(ST_H, 3);
    drain(3);

    // MEM_WAIT = 1 and 15
    run_x[0] = 1'b1; run_x[1] = 1'b1;
    for (int g = 0; g < 2; g++) begin
      oe_cnt[g] = 0; mdr_cnt[g] = 0; mdr_at[g] = 0; mdr_oe[g] = 0; runs[g] = 0; prev_oe[g] = 1'b1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      run_x[0] = 1'b0; run_x[1] = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (!oe_x[g]) oe_cnt[g]++;
        if (!oe_x[g] && prev_oe[g]) runs[g]++;
        prev_oe[g] = oe_x[g];
        if (mdr_x[g]) begin
          mdr_cnt[g]++;
          mdr_at[g] = oe_cnt[g];
          mdr_oe[g] = int'(!oe_x[g]);
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      check("wait_oe_cycles", oe_cnt[g], WV[g]);
      check("wait_oe_runs", runs[g], 1);
      check("wait_mdr_pulses", mdr_cnt[g], 1);
      check("wait_mdr_pos", mdr_at[g], WV[g]);
      check("wait_mdr_with_oe", mdr_oe[g], 1);
    end

    // Reset in the middle of the memory read
    @(negedge Clk);
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    check("pre_s18_ldmar", LD_MAR, 1'b1);
    @(negedge Clk);
    check("pre_s33_oe", Mem_OE_N, 1'b0);
    Reset = 1'b1;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_oe", Mem_OE_N, 1'b1);
    check("async_vec", obs, ev(ST_H, 1'b0));
    @(negedge Clk);
    Reset = 1'b0;
    push_n(ST_H, 4);
    drain(4);
    check("after_rst_count", fetch_count, 16'h0000);

    // First fetch from HALTED
    Run = 1'b1;
    push_fetch(2);
    drain(5);
    check("fetch1_count", fetch_count, 16'h0001);
    push_n(ST_P1, 2);
    drain(2);

    // Three presses of 3 cycles each
    for (int p = 0; p < 3; p++) begin
      Continue = 1'b1;
      push_n(ST_P2, 3);
      drain(3);
      Continue = 1'b0;
      push_fetch(2);
      drain(5);
    end
    check("press_count", fetch_count, 16'h0004);

    // Continue held: parks in PAUSE2; high on PAUSE1 entry gives a 1-cycle PAUSE1
    Continue = 1'b1;
    push_n(ST_P2, 5);
    drain(5);
    Continue = 1'b0;
    push_fetch(2);
    drain(1);
    Continue = 1'b1;
    push_n(ST_P2, 4);
    drain(8);
    check("held_count", fetch_count, 16'h0005);

    // fetch_count wrap
    force dut.fetch_count_q = 16'hFFFF;
    #1 release dut.fetch_count_q;
    #1;
    check("preload_count", fetch_count, 16'hFFFF);
    Continue = 1'b0;
    push_fetch(2);
    drain(5);
    check("wrap_count", fetch_count, 16'h0000);
    check("wrap_busy", busy, 1'b1);

    // Run and Continue together in HALTED: Run wins
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    Run = 1'b1;
    Continue = 1'b1;
    push_fetch(2);
    push_n(ST_P2, 2);
    drain(7);
    check("runcont_count", fetch_count, 16'h0001);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
